// File: rtl/link_fault_pkg.sv
// Shared encodings for the RX link fault state machine: fault types, FSM states and a clog2 helper.
package link_fault_pkg;

   localparam logic [1:0] LINK_FAULT_OK     = 2'd0;
   localparam logic [1:0] LINK_FAULT_LOCAL  = 2'd1;
   localparam logic [1:0] LINK_FAULT_REMOTE = 2'd2;

   typedef enum logic [1:0] {
      SM_INIT      = 2'd0,
      SM_COUNT     = 2'd1,
      SM_FAULT     = 2'd2,
      SM_NEW_FAULT = 2'd3
   } sm_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/link_fault_sm_mc_fault_popcount.sv
// Counts set bits in a column detect vector; gives the per-cycle sequence increment.
module fault_popcount #(
   parameter int COLS  = 2,
   parameter int OUT_W = 2
) (
   input  logic [COLS-1:0]  vec_i,
   output logic [OUT_W-1:0] cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < COLS; i++) cnt_o = cnt_o + OUT_W'(vec_i[i]);
   end

endmodule

// File: rtl/link_fault_sm_mc.sv
// Receive-side link fault state machine for the XGMII RX domain, COLS columns per clock.
// Optional per-type fault-entry statistics are built when LINK_FAULT_STATS_EN is defined.
//
//  state        | meaning
//  SM_INIT      | no fault sequence seen; waiting for the first one
//  SM_COUNT     | qualifying sequences of one type inside the column window
//  SM_FAULT     | fault qualified; link_fault holds the type until the window expires
//  SM_NEW_FAULT | one-cycle restart after a sequence of a different type
module link_fault_sm_mc
   import link_fault_pkg::*;
#(
   parameter int COLS       = 2,
   parameter int WINDOW     = 128,
   parameter int SEQ_THRESH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk_xgmii_rx,
   input  logic             reset_xgmii_rx_n,
   input  logic [COLS-1:0]  local_fault_msg_det,
   input  logic [COLS-1:0]  remote_fault_msg_det,
   input  logic             clear_stats,
   output logic             status_local_fault_crx,
   output logic             status_remote_fault_crx,
   output logic [1:0]       link_fault,
   output logic             fault_change,
   output logic [CNT_W-1:0] local_fault_cnt,
   output logic [CNT_W-1:0] remote_fault_cnt
);

   // Headroom covers a same-type burst that keeps counting past expiry until threshold.
   localparam int COL_W = clog2(WINDOW + (SEQ_THRESH + 1) * COLS + 1);
   localparam int SEQ_W = clog2(SEQ_THRESH + 2 * COLS + 1);
   localparam int ADD_W = clog2(COLS + 1);

   sm_state_e        state_q, state_d;
   logic [COL_W-1:0] col_cnt_q, col_cnt_d, col_sum;
   logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d, seq_sum;
   logic [1:0]       last_seq_type_q, last_seq_type_d;
   logic [1:0]       link_fault_q, link_fault_d, link_fault_prev_q;
   logic             status_local_q, status_local_d;
   logic             status_remote_q, status_remote_d;
   logic             fault_change_q, fault_change_d;
   logic             fault_any, expire, thresh_hit, fault_entry;
   logic [1:0]       seq_type;
   logic [COLS-1:0]  sel_vec;
   logic [ADD_W-1:0] seq_add;

   always_comb begin
      fault_any = |(local_fault_msg_det | remote_fault_msg_det);
      seq_type  = LINK_FAULT_OK;
      sel_vec   = '0;
      if (|local_fault_msg_det) begin
         seq_type = LINK_FAULT_LOCAL;
         sel_vec  = local_fault_msg_det;
      end else if (|remote_fault_msg_det) begin
         seq_type = LINK_FAULT_REMOTE;
         sel_vec  = remote_fault_msg_det;
      end
   end

   fault_popcount #(.COLS(COLS), .OUT_W(ADD_W)) u_popcount (
      .vec_i (sel_vec),
      .cnt_o (seq_add)
   );

   assign col_sum    = col_cnt_q + COL_W'(COLS);
   assign seq_sum    = seq_cnt_q + SEQ_W'(seq_add);
   assign expire     = (col_sum >= COL_W'(WINDOW));
   assign thresh_hit = (seq_sum >= SEQ_W'(SEQ_THRESH));

   always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
      if (!reset_xgmii_rx_n) begin
         state_q           <= SM_INIT;
         col_cnt_q         <= '0;
         seq_cnt_q         <= '0;
         last_seq_type_q   <= LINK_FAULT_OK;
         link_fault_q      <= LINK_FAULT_OK;
         link_fault_prev_q <= LINK_FAULT_OK;
         status_local_q    <= 1'b0;
         status_remote_q   <= 1'b0;
         fault_change_q    <= 1'b0;
      end else begin
         state_q           <= state_d;
         col_cnt_q         <= col_cnt_d;
         seq_cnt_q         <= seq_cnt_d;
         last_seq_type_q   <= last_seq_type_d;
         link_fault_q      <= link_fault_d;
         link_fault_prev_q <= link_fault_q;
         status_local_q    <= status_local_d;
         status_remote_q   <= status_remote_d;
         fault_change_q    <= fault_change_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      col_cnt_d       = col_cnt_q;
      seq_cnt_d       = seq_cnt_q;
      last_seq_type_d = last_seq_type_q;
      link_fault_d    = link_fault_q;
      fault_entry     = 1'b0;
      unique case (state_q)
         SM_INIT: begin
            if (fault_any) begin
               last_seq_type_d = seq_type;
               seq_cnt_d       = SEQ_W'(seq_add);
               col_cnt_d       = COL_W'(COLS);
               state_d         = SM_COUNT;
            end else begin
               col_cnt_d = '0;
               seq_cnt_d = '0;
            end
         end
         SM_COUNT: begin
            if (fault_any && seq_type != last_seq_type_q) begin
               last_seq_type_d = seq_type;
               seq_cnt_d       = SEQ_W'(seq_add);
               col_cnt_d       = '0;
               state_d         = SM_NEW_FAULT;
            end else if (fault_any && thresh_hit) begin
               link_fault_d = seq_type;
               col_cnt_d    = '0;
               state_d      = SM_FAULT;
               fault_entry  = 1'b1;
            end else if (expire && !fault_any) begin
               state_d = SM_INIT;
            end else begin
               col_cnt_d = col_sum;
               seq_cnt_d = seq_sum;
            end
         end
         SM_FAULT: begin
            if (fault_any && seq_type == last_seq_type_q) begin
               col_cnt_d = '0;
            end else if (fault_any) begin
               last_seq_type_d = seq_type;
               seq_cnt_d       = SEQ_W'(seq_add);
               col_cnt_d       = '0;
               state_d         = SM_NEW_FAULT;
            end else if (expire) begin
               link_fault_d = LINK_FAULT_OK;
               state_d      = SM_INIT;
            end else begin
               col_cnt_d = col_sum;
            end
         end
         SM_NEW_FAULT: begin
            col_cnt_d = COL_W'(COLS);
            if (seq_type == last_seq_type_q) seq_cnt_d = seq_sum;
            state_d = SM_COUNT;
         end
         default: state_d = SM_INIT;
      endcase
   end

   always_comb begin
      status_local_d  = (state_q == SM_FAULT) && (link_fault_q == LINK_FAULT_LOCAL);
      status_remote_d = (state_q == SM_FAULT) && (link_fault_q == LINK_FAULT_REMOTE);
      fault_change_d  = (link_fault_q != link_fault_prev_q);
   end

   assign status_local_fault_crx  = status_local_q;
   assign status_remote_fault_crx = status_remote_q;
   assign link_fault              = link_fault_q;
   assign fault_change            = fault_change_q;

`ifdef LINK_FAULT_STATS_EN
   logic [CNT_W-1:0] local_cnt_q, remote_cnt_q;

   // A clear in the same cycle as an entry drops that entry.
   always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
      if (!reset_xgmii_rx_n) begin
         local_cnt_q  <= '0;
         remote_cnt_q <= '0;
      end else if (clear_stats) begin
         local_cnt_q  <= '0;
         remote_cnt_q <= '0;
      end else if (fault_entry) begin
         if (link_fault_d == LINK_FAULT_LOCAL && !(&local_cnt_q))
            local_cnt_q <= local_cnt_q + 1'b1;
         if (link_fault_d == LINK_FAULT_REMOTE && !(&remote_cnt_q))
            remote_cnt_q <= remote_cnt_q + 1'b1;
      end
   end

   assign local_fault_cnt  = local_cnt_q;
   assign remote_fault_cnt = remote_cnt_q;
`else
   logic [1:0] unused_stats;
   assign unused_stats     = {clear_stats, fault_entry};
   assign local_fault_cnt  = '0;
   assign remote_fault_cnt = '0;
`endif

endmodule

// File: tb/tb_link_fault_sm_mc.sv
// Scoreboard bench for link_fault_sm_mc: timeline-based reference model feeds an expected queue.
module tb_link_fault_sm_mc;

   localparam int COLS       = 2;
   localparam int WINDOW     = 128;
   localparam int SEQ_THRESH = 4;
   localparam int CNT_W      = 2;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [1:0]       lf;
      logic             sl;
      logic             sr;
      logic             fc;
      logic [CNT_W-1:0] lc;
      logic [CNT_W-1:0] rc;
   } obs_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [COLS-1:0]  local_det = '0;
   logic [COLS-1:0]  remote_det = '0;
   logic             clr = 1'b0;
   logic             st_local, st_remote, fchg;
   logic [1:0]       lf;
   logic [CNT_W-1:0] lcnt, rcnt;

   link_fault_sm_mc #(
      .COLS(COLS), .WINDOW(WINDOW), .SEQ_THRESH(SEQ_THRESH), .CNT_W(CNT_W)
   ) dut (
      .clk_xgmii_rx            (clk),
      .reset_xgmii_rx_n        (rst_n),
      .local_fault_msg_det     (local_det),
      .remote_fault_msg_det    (remote_det),
      .clear_stats             (clr),
      .status_local_fault_crx  (st_local),
      .status_remote_fault_crx (st_remote),
      .link_fault              (lf),
      .fault_change            (fchg),
      .local_fault_cnt         (lcnt),
      .remote_fault_cnt        (rcnt)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   obs_t exp_q[$];

   // Reference model: mode 0 idle, 1 qualifying, 2 fault held, 3 restart after type switch.
   // The column position is derived from the cycle number since the window was last anchored.
   int m_mode, m_type, m_hits, m_lf, m_lf_prev, m_base, m_t0, m_t, m_lc, m_rc;

   function automatic obs_t observe();
      return {lf, st_local, st_remote, fchg, lcnt, rcnt};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_type = 0; m_hits = 0; m_lf = 0; m_lf_prev = 0;
      m_base = 0; m_t0 = 0; m_t = 0; m_lc = 0; m_rc = 0;
   endtask

   task automatic anchor(input int cols_next);
      m_base = cols_next;
      m_t0   = m_t + 1;
   endtask

   task automatic model_step(input logic [COLS-1:0] lv, input logic [COLS-1:0] rv, input logic c);
      bit   any, expire, entry;
      int   typ, add, col;
      obs_t e;
      any    = (lv | rv) != 0;
      typ    = (lv != 0) ? 1 : ((rv != 0) ? 2 : 0);
      add    = (typ == 1) ? $countones(lv) : ((typ == 2) ? $countones(rv) : 0);
      col    = m_base + (m_t - m_t0) * COLS;
      expire = (col + COLS >= WINDOW);
      entry  = 0;
      e.sl   = (m_mode == 2) && (m_lf == 1);
      e.sr   = (m_mode == 2) && (m_lf == 2);
      e.fc   = (m_lf != m_lf_prev);
      m_lf_prev = m_lf;
      case (m_mode)
         0: if (any) begin
               m_type = typ; m_hits = add; anchor(COLS); m_mode = 1;
            end
         1: if (any && typ != m_type) begin
               m_type = typ; m_hits = add; anchor(0); m_mode = 3;
            end else if (any && m_hits + add >= SEQ_THRESH) begin
               m_lf = typ; anchor(0); m_mode = 2; entry = 1;
            end else if (expire && !any) begin
               m_mode = 0;
            end else begin
               m_hits += add;
            end
         2: if (any && typ == m_type) begin
               anchor(0);
            end else if (any) begin
               m_type = typ; m_hits = add; anchor(0); m_mode = 3;
            end else if (expire) begin
               m_lf = 0; m_mode = 0;
            end
         default: begin
            anchor(COLS);
            if (typ == m_type) m_hits += add;
            m_mode = 1;
         end
      endcase
      m_t++;
`ifdef LINK_FAULT_STATS_EN
      if (c) begin
         m_lc = 0; m_rc = 0;
      end else if (entry) begin
         if (m_lf == 1 && m_lc < CNT_MAX) m_lc++;
         if (m_lf == 2 && m_rc < CNT_MAX) m_rc++;
      end
`endif
      e.lf = 2'(m_lf);
      e.lc = CNT_W'(m_lc);
      e.rc = CNT_W'(m_rc);
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      obs_t e, g;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = observe();
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL outputs cyc=%0d got lf=%0d sl=%0b sr=%0b fc=%0b lc=%0d rc=%0d need lf=%0d sl=%0b sr=%0b fc=%0b lc=%0d rc=%0d",
                     cyc, g.lf, g.sl, g.sr, g.fc, g.lc, g.rc, e.lf, e.sl, e.sr, e.fc, e.lc, e.rc);
         end
      end
   end

   task automatic cycle(input logic [COLS-1:0] lv, input logic [COLS-1:0] rv, input logic c);
      local_det  = lv;
      remote_det = rv;
      clr        = c;
      @(posedge clk);
      model_step(lv, rv, c);
      cyc++;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
   endtask

   task automatic spaced(input logic [COLS-1:0] lv, input logic [COLS-1:0] rv, input int gap, input int n);
      for (int i = 0; i < n; i++) begin
         cycle(lv, rv, 1'b0);
         idle(gap - 1);
      end
   endtask

   task automatic check_zero(input string name);
      obs_t g;
      g = observe();
      checks++;
      if (g !== '0) begin
         errors++;
         $display("FAIL %s got %h need 0", name, g);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout cyc=%0d pending=%0d", cyc, exp_q.size());
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #23;
      check_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      idle(3);
      cycle(2'b11, 2'b00, 1'b0);
      cycle(2'b11, 2'b00, 1'b0);
      idle(70);
      spaced(2'b01, 2'b00, 20, 4);
      idle(70);
      spaced(2'b01, 2'b00, 22, 4);
      idle(70);
      cycle(2'b11, 2'b00, 1'b0);
      cycle(2'b11, 2'b00, 1'b0);
      idle(3);
      cycle(2'b00, 2'b11, 1'b0);
      cycle(2'b00, 2'b11, 1'b0);
      cycle(2'b00, 2'b01, 1'b0);
      idle(70);
      for (int i = 0; i < 4; i++) cycle(2'b01, 2'b11, 1'b0);
      idle(70);
      for (int i = 0; i < 5; i++) begin
         cycle(2'b11, 2'b00, 1'b0);
         cycle(2'b11, 2'b00, 1'b0);
         idle(66);
      end
      cycle(2'b11, 2'b00, 1'b0);
      cycle(2'b11, 2'b00, 1'b1);
      idle(4);

      cycle(2'b00, 2'b11, 1'b0);
      cycle(2'b00, 2'b11, 1'b0);
      idle(3);
      rst_n = 1'b0;
      #1;
      check_zero("reset_mid_fault");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      for (int s = 0; s < 60; s++) begin
         int kind, len;
         kind = $urandom_range(0, 4);
         len  = (kind == 0) ? $urandom_range(10, 80) : $urandom_range(1, 12);
         for (int k = 0; k < len; k++) begin
            logic [COLS-1:0] lv, rv;
            logic            c;
            c  = ($urandom_range(0, 15) == 0);
            lv = '0;
            rv = '0;
            case (kind)
               1: begin lv = COLS'($urandom); rv = COLS'($urandom); end
               2: lv = ($urandom_range(0, 3) == 0) ? COLS'($urandom_range(1, 3)) : '0;
               3: rv = ($urandom_range(0, 1) == 0) ? COLS'($urandom_range(1, 3)) : '0;
               4: if ($urandom_range(0, 19) == 0) lv = 2'b01;
               default: ;
            endcase
            cycle(lv, rv, c);
         end
      end
      idle(70);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending need 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
